upd7800_bus_target: RTL and testbench

- Bus responder at the far end of the uPD7800 external bus (A, DB, M1, RDB, WRB).
- Serves CPU reads and writes from a 128-byte on-chip RAM window. All other addresses are bridged to a slower backing-memory port with a req/ack handshake.
- Counts M1 opcode fetches for debug.
- Flags protocol and handshake errors with a sticky error bit.

---
 rtl/upd7800_bus_target.sv | 251 +++++++++++++++++++++++++
 tb/tb_upd7800_bus_target.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/upd7800_bus_target.sv
// uPD7800 external-bus responder: 128-byte on-chip RAM window, everything else
// bridged to a req/ack backing-memory port, plus an M1 fetch counter and sticky error.
module upd7800_bus_target #(
    parameter logic [15:0] RAM_BASE = 16'hFF80,
    parameter int          TIMEOUT  = 15
) (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic [15:0] A,
    input  logic [7:0]  DB_I,
    output logic [7:0]  DB_O,
    output logic        DB_OE,
    input  logic        M1,
    input  logic        RDB,
    input  logic        WRB,
    output logic [15:0] MEM_A,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [7:0]  MEM_D,
    input  logic [7:0]  MEM_Q,
    input  logic        MEM_ACK,
    output logic [15:0] FETCH_CNT,
    output logic        ERR,
    input  logic        ERR_CLR
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_RAM  = 3'd1,
        S_RD_EXT  = 3'd2,
        S_RD_HOLD = 3'd3,
        S_WR_EXT  = 3'd4
    } state_t;

    // Last counter value before the wait is declared expired.
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    function automatic logic is_ram_hit(input logic [15:0] addr);
        return (addr & 16'hFF80) == RAM_BASE;
    endfunction

    state_t      state_q, state_d;
    logic        rdb_q, wrb_q;
    logic [15:0] wa_q, wa_d;
    logic [7:0]  wd_q, wd_d;
    logic [7:0]  db_o_q, db_o_d;
    logic        db_oe_q, db_oe_d;
    logic [15:0] mem_a_q, mem_a_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_d_q, mem_d_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic        err_q, err_d;
    logic        rd_start_s, wr_commit_s, err_set_s, ram_we_s;
    logic [7:0]  ram [0:127];

    assign rd_start_s  = rdb_q & ~RDB;
    assign wr_commit_s = ~wrb_q & WRB;

    // Next-state, datapath and error logic.
    always_comb begin
        state_d     = state_q;
        wa_d        = wa_q;
        wd_d        = wd_q;
        db_o_d      = db_o_q;
        db_oe_d     = 1'b0;
        mem_a_d     = mem_a_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_d_d     = mem_d_q;
        cnt_d       = cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        err_set_s   = 1'b0;
        ram_we_s    = 1'b0;

        if (!WRB) begin
            wa_d = A;
            wd_d = DB_I;
        end else begin
            wa_d = wa_q;
            wd_d = wd_q;
        end

        if (rd_start_s && M1) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end

        if (!RDB && !WRB) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (rd_start_s) begin
                    // A simultaneous write commit loses to the read.
                    if (wr_commit_s) begin
                        err_set_s = 1'b1;
                    end else begin
                        err_set_s = err_set_s;
                    end
                    if (is_ram_hit(A)) begin
                        state_d = S_RD_RAM;
                    end else begin
                        mem_a_d   = A;
                        mem_we_d  = 1'b0;
                        mem_req_d = 1'b1;
                        cnt_d     = 4'd0;
                        state_d   = S_RD_EXT;
                    end
                end else if (wr_commit_s) begin
                    if (is_ram_hit(wa_q)) begin
                        ram_we_s = 1'b1;
                    end else begin
                        mem_a_d   = wa_q;
                        mem_d_d   = wd_q;
                        mem_we_d  = 1'b1;
                        mem_req_d = 1'b1;
                        cnt_d     = 4'd0;
                        state_d   = S_WR_EXT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_RAM: begin
                db_o_d  = ram[A[6:0]];
                db_oe_d = ~RDB;
                state_d = S_RD_HOLD;
            end
            S_RD_EXT: begin
                if (MEM_ACK) begin
                    db_o_d    = MEM_Q;
                    db_oe_d   = ~RDB;
                    mem_req_d = 1'b0;
                    state_d   = S_RD_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    db_o_d    = 8'hFF;
                    db_oe_d   = ~RDB;
                    err_set_s = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_RD_HOLD;
                end else if (RDB) begin
                    mem_req_d = 1'b0;
                    err_set_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD_HOLD: begin
                if (RDB) begin
                    db_oe_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    db_oe_d = 1'b1;
                end
            end
            S_WR_EXT: begin
                if (MEM_ACK) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    err_set_s = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = S_IDLE;
            end
        endcase

        if (state_q != S_IDLE && (rd_start_s || wr_commit_s)) begin
            err_set_s = 1'b1;
        end else begin
            err_set_s = err_set_s;
        end

        // A set event in the same clock overrides the clear.
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (ERR_CLR) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q     <= S_IDLE;
            rdb_q       <= 1'b1;
            wrb_q       <= 1'b1;
            wa_q        <= 16'h0000;
            wd_q        <= 8'h00;
            db_o_q      <= 8'h00;
            db_oe_q     <= 1'b0;
            mem_a_q     <= 16'h0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_d_q     <= 8'h00;
            cnt_q       <= 4'd0;
            fetch_cnt_q <= 16'h0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdb_q       <= RDB;
            wrb_q       <= WRB;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            db_o_q      <= db_o_d;
            db_oe_q     <= db_oe_d;
            mem_a_q     <= mem_a_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_d_q     <= mem_d_d;
            cnt_q       <= cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            err_q       <= err_d;
        end
    end

    // RAM array; contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we_s) begin
            ram[wa_q[6:0]] <= wd_q;
        end
    end

    assign DB_O      = db_o_q;
    assign DB_OE     = db_oe_q;
    assign MEM_A     = mem_a_q;
    assign MEM_REQ   = mem_req_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_D     = mem_d_q;
    assign FETCH_CNT = fetch_cnt_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_upd7800_bus_target.sv
// Directed bench for upd7800_bus_target: inputs change and outputs are sampled on the falling clock edge.
module tb_upd7800_bus_target;

    logic        CLK = 1'b0;
    logic        RESETB;
    logic [15:0] A;
    logic [7:0]  DB_I;
    logic [7:0]  DB_O;
    logic        DB_OE;
    logic        M1, RDB, WRB;
    logic [15:0] MEM_A;
    logic        MEM_REQ, MEM_WE;
    logic [7:0]  MEM_D, MEM_Q;
    logic        MEM_ACK;
    logic [15:0] FETCH_CNT;
    logic        ERR, ERR_CLR;

    int checks_cnt = 0;
    int errors_cnt = 0;

    upd7800_bus_target #(.RAM_BASE(16'hFF80), .TIMEOUT(15)) dut (
        .CLK(CLK), .RESETB(RESETB), .A(A), .DB_I(DB_I), .DB_O(DB_O), .DB_OE(DB_OE),
        .M1(M1), .RDB(RDB), .WRB(WRB), .MEM_A(MEM_A), .MEM_REQ(MEM_REQ),
        .MEM_WE(MEM_WE), .MEM_D(MEM_D), .MEM_Q(MEM_Q), .MEM_ACK(MEM_ACK),
        .FETCH_CNT(FETCH_CNT), .ERR(ERR), .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts further consecutive falling edges with MEM_REQ high (bounded).
    task automatic count_req(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (MEM_REQ) n++;
            else break;
        end
    endtask

    task automatic ram_write(input logic [15:0] addr, input logic [7:0] data);
        A = addr; DB_I = data; WRB = 1'b0;
        repeat (3) @(negedge CLK);
        WRB = 1'b1;
        @(negedge CLK);
        check_eq("ram_wr_noreq", MEM_REQ, 16'd0);
    endtask

    task automatic ram_read(input logic [15:0] addr, input logic m1, input logic [7:0] exp);
        A = addr; RDB = 1'b0; M1 = m1;
        @(negedge CLK);
        check_eq("ram_rd_oe_early", DB_OE, 16'd0);
        @(negedge CLK);
        check_eq("ram_rd_oe", DB_OE, 16'd1);
        check_eq("ram_rd_data", DB_O, 16'(exp));
        check_eq("ram_rd_noreq", MEM_REQ, 16'd0);
        RDB = 1'b1; M1 = 1'b0;
        @(negedge CLK);
        check_eq("ram_rd_oe_drop", DB_OE, 16'd0);
    endtask

    task automatic clear_err();
        ERR_CLR = 1'b1;
        @(negedge CLK);
        ERR_CLR = 1'b0;
        check_eq("err_clr", ERR, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        RESETB = 1'b0; A = 16'h0000; DB_I = 8'h00; M1 = 1'b0; RDB = 1'b1; WRB = 1'b1;
        MEM_Q = 8'h00; MEM_ACK = 1'b0; ERR_CLR = 1'b0;
        #1;
        check_eq("rst_db_o", DB_O, 16'd0);
        check_eq("rst_db_oe", DB_OE, 16'd0);
        check_eq("rst_req", MEM_REQ, 16'd0);
        check_eq("rst_we", MEM_WE, 16'd0);
        check_eq("rst_mem_a", MEM_A, 16'd0);
        check_eq("rst_mem_d", MEM_D, 16'd0);
        check_eq("rst_fetch", FETCH_CNT, 16'd0);
        check_eq("rst_err", ERR, 16'd0);
        repeat (2) @(negedge CLK);
        RESETB = 1'b1;
        @(negedge CLK);

        // RAM write then read back
        ram_write(16'hFF90, 8'h5A);
        ram_read(16'hFF90, 1'b0, 8'h5A);
        ram_write(16'hFFFF, 8'hA7);
        ram_read(16'hFFFF, 1'b0, 8'hA7);
        check_eq("ram_err", ERR, 16'd0);

        // External read acked on the 4th request cycle
        A = 16'h1234; RDB = 1'b0;
        @(negedge CLK);
        check_eq("xr_req", MEM_REQ, 16'd1);
        check_eq("xr_a", MEM_A, 16'h1234);
        check_eq("xr_we", MEM_WE, 16'd0);
        repeat (2) @(negedge CLK);
        check_eq("xr_req3", MEM_REQ, 16'd1);
        MEM_ACK = 1'b1; MEM_Q = 8'hC3;
        @(negedge CLK);
        MEM_ACK = 1'b0; MEM_Q = 8'h00;
        check_eq("xr_req_drop", MEM_REQ, 16'd0);
        check_eq("xr_oe", DB_OE, 16'd1);
        check_eq("xr_data", DB_O, 16'h00C3);
        @(negedge CLK);
        check_eq("xr_oe_hold", DB_OE, 16'd1);
        RDB = 1'b1;
        @(negedge CLK);
        check_eq("xr_oe_drop", DB_OE, 16'd0);
        check_eq("xr_err", ERR, 16'd0);

        // Stray ack while idle is ignored
        MEM_ACK = 1'b1; MEM_Q = 8'h99;
        @(negedge CLK);
        MEM_ACK = 1'b0;
        check_eq("stray_ack_req", MEM_REQ, 16'd0);
        check_eq("stray_ack_oe", DB_OE, 16'd0);
        check_eq("stray_ack_db", DB_O, 16'h00C3);

        // External write never acked -> timeout
        A = 16'h8000; DB_I = 8'h77; WRB = 1'b0;
        @(negedge CLK);
        WRB = 1'b1;
        @(negedge CLK);
        check_eq("xw_req", MEM_REQ, 16'd1);
        check_eq("xw_we", MEM_WE, 16'd1);
        check_eq("xw_d", MEM_D, 16'h0077);
        check_eq("xw_a", MEM_A, 16'h8000);
        count_req(n);
        check_eq("xw_req_cycles", 16'(n + 1), 16'd15);
        check_eq("xw_we_drop", MEM_WE, 16'd0);
        check_eq("xw_err", ERR, 16'd1);
        clear_err();

        // External read timeout
        A = 16'h4000; RDB = 1'b0;
        count_req(n);
        check_eq("xrt_req_cycles", 16'(n), 16'd15);
        check_eq("xrt_data", DB_O, 16'h00FF);
        check_eq("xrt_oe", DB_OE, 16'd1);
        check_eq("xrt_err", ERR, 16'd1);
        RDB = 1'b1;
        @(negedge CLK);
        check_eq("xrt_oe_drop", DB_OE, 16'd0);
        clear_err();

        // External read aborted by early RDB rise
        A = 16'h4000; RDB = 1'b0;
        @(negedge CLK);
        check_eq("abort_req", MEM_REQ, 16'd1);
        RDB = 1'b1;
        @(negedge CLK);
        check_eq("abort_req_drop", MEM_REQ, 16'd0);
        check_eq("abort_oe", DB_OE, 16'd0);
        check_eq("abort_err", ERR, 16'd1);
        @(negedge CLK);
        check_eq("abort_oe2", DB_OE, 16'd0);
        clear_err();

        // RDB and WRB low together: read wins, write is dropped
        A = 16'hFF90; DB_I = 8'h11; RDB = 1'b0; WRB = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("both_err", ERR, 16'd1);
        check_eq("both_rd_data", DB_O, 16'h005A);
        RDB = 1'b1; WRB = 1'b1;
        @(negedge CLK);
        clear_err();
        ram_read(16'hFF90, 1'b0, 8'h5A);

        // Fetch counting and wrap
        ram_read(16'hFF90, 1'b1, 8'h5A);
        ram_read(16'hFFFF, 1'b1, 8'hA7);
        ram_read(16'hFF90, 1'b0, 8'h5A);
        ram_read(16'hFF90, 1'b1, 8'h5A);
        check_eq("fetch_cnt3", FETCH_CNT, 16'd3);
        force dut.fetch_cnt_q = 16'hFFFF;
        @(negedge CLK);
        release dut.fetch_cnt_q;
        @(negedge CLK);
        check_eq("fetch_preload", FETCH_CNT, 16'hFFFF);
        ram_read(16'hFF90, 1'b1, 8'h5A);
        check_eq("fetch_wrap", FETCH_CNT, 16'h0000);

        // Asynchronous reset in the middle of an external read
        A = 16'h2000; RDB = 1'b0;
        @(negedge CLK);
        check_eq("ar_req", MEM_REQ, 16'd1);
        #2;
        RESETB = 1'b0; RDB = 1'b1;
        #1;
        check_eq("ar_req_async", MEM_REQ, 16'd0);
        check_eq("ar_oe_async", DB_OE, 16'd0);
        @(negedge CLK);
        RESETB = 1'b1;
        @(negedge CLK);
        check_eq("ar_req_after", MEM_REQ, 16'd0);
        check_eq("ar_err_after", ERR, 16'd0);
        ram_read(16'hFF90, 1'b0, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
